// File: rtl/core_control_ldst_reglist_pkg.sv
// Shared micro-architectural types for the LDM/STM register-list sequencer.
//   reg_num_t   : architectural register number
//   ptr_t       : word address (byte address bits [31:2])
//   ldst_mode_e : block-transfer addressing mode, encoded as {pre_index, increment}
//   state_e     : sequencer state
package core_control_ldst_reglist_pkg;

   localparam int unsigned DefNregs  = 16;
   localparam int unsigned DefAddrW  = 30;
   localparam int unsigned RegNumW   = $clog2(DefNregs);

   typedef logic [RegNumW-1:0]  reg_num_t;
   typedef logic [DefAddrW-1:0] ptr_t;

   typedef enum logic [1:0] {
      LdstDa = 2'b00,
      LdstIa = 2'b01,
      LdstDb = 2'b10,
      LdstIb = 2'b11
   } ldst_mode_e;

   typedef enum logic {
      StIdle   = 1'b0,
      StActive = 1'b1
   } state_e;

   function automatic ldst_mode_e ldst_mode(input logic pre_index, input logic increment);
      return ldst_mode_e'({pre_index, increment});
   endfunction

endpackage

// File: rtl/core_control_ldst_reglist_prio.sv
// Lowest-set-bit priority encoder over the remaining register mask.
//   mask_i    : remaining register list
//   idx_o     : index of the lowest set bit (0 when mask is empty)
//   clr_o     : one-hot of the lowest set bit
//   single_o  : exactly one bit set
//   nonzero_o : at least one bit set
module core_control_ldst_reglist_prio #(
   parameter  int unsigned NREGS = 16,
   localparam int unsigned IDX_W = $clog2(NREGS)
) (
   input  logic [NREGS-1:0] mask_i,
   output logic [IDX_W-1:0] idx_o,
   output logic [NREGS-1:0] clr_o,
   output logic             single_o,
   output logic             nonzero_o
);

   // Two's-complement trick isolates the lowest set bit.
   assign clr_o     = mask_i & (~mask_i + NREGS'(1));
   assign nonzero_o = |mask_i;
   assign single_o  = nonzero_o && ((mask_i & (mask_i - NREGS'(1))) == '0);

   // Scan high to low so the lowest set bit wins.
   always_comb begin
      idx_o = '0;
      for (int i = int'(NREGS) - 1; i >= 0; i--) begin
         if (mask_i[i]) idx_o = IDX_W'(i);
      end
   end

endmodule

// File: rtl/core_control_ldst_reglist.sv
// LDM/STM register-list sequencer. Latches a register list and base on start, then presents
// one register per beat (lowest first, ascending addresses) until the list is drained.
//   clk, rst_n      : clock, asynchronous active-low reset
//   start_i         : latch a new transfer (wins over advance/flush)
//   reglist_i       : register list
//   base_i          : base word address
//   increment_i     : 1 = IA/IB, 0 = DA/DB
//   pre_index_i     : 1 = IB/DB
//   advance_i       : current beat accepted
//   flush_i         : abort the sequence without a done pulse
//   pop_valid_o     : popped_o/addr_o valid
//   popped_o        : register number of current beat
//   addr_o          : word address of current beat
//   last_o          : current beat is the final one
//   busy_o          : sequence in progress
//   done_o          : one-cycle pulse after the final beat is accepted
//   wb_addr_o       : base writeback value
module core_control_ldst_reglist
   import core_control_ldst_reglist_pkg::*;
#(
   parameter  int unsigned ADDR_W = DefAddrW,
   parameter  int unsigned NREGS  = DefNregs,
   localparam int unsigned IDX_W  = $clog2(NREGS),
   localparam int unsigned CNT_W  = $clog2(NREGS + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_i,
   input  logic [NREGS-1:0]  reglist_i,
   input  logic [ADDR_W-1:0] base_i,
   input  logic              increment_i,
   input  logic              pre_index_i,
   input  logic              advance_i,
   input  logic              flush_i,
   output logic              pop_valid_o,
   output logic [IDX_W-1:0]  popped_o,
   output logic [ADDR_W-1:0] addr_o,
   output logic              last_o,
   output logic              busy_o,
   output logic              done_o,
   output logic [ADDR_W-1:0] wb_addr_o
);

   localparam logic [ADDR_W-1:0] AddrOne = ADDR_W'(1);

   state_e              state_q, state_d;
   logic [NREGS-1:0]    mask_q, mask_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [ADDR_W-1:0]   wb_addr_q, wb_addr_d;
   logic                done_q, done_d;

   logic [CNT_W-1:0]    cnt;
   logic [ADDR_W-1:0]   cnt_ext;
   logic [ADDR_W-1:0]   start_addr;
   logic [IDX_W-1:0]    low_idx;
   logic [NREGS-1:0]    low_clr;
   logic                mask_single;
   logic                mask_nonzero;
   logic                active;

   core_control_ldst_reglist_prio #(
      .NREGS (NREGS)
   ) u_prio (
      .mask_i    (mask_q),
      .idx_o     (low_idx),
      .clr_o     (low_clr),
      .single_o  (mask_single),
      .nonzero_o (mask_nonzero)
   );

   // Number of registers in the incoming list.
   always_comb begin
      cnt = '0;
      for (int i = 0; i < int'(NREGS); i++) begin
         cnt = cnt + CNT_W'(reglist_i[i]);
      end
   end

   assign cnt_ext = ADDR_W'(cnt);

   // Beats always walk upward, so decrementing modes start at the bottom of the block.
   always_comb begin
      case (ldst_mode(pre_index_i, increment_i))
         LdstIa:  start_addr = base_i;
         LdstIb:  start_addr = base_i + AddrOne;
         LdstDa:  start_addr = base_i - cnt_ext + AddrOne;
         LdstDb:  start_addr = base_i - cnt_ext;
         default: start_addr = base_i;
      endcase
   end

   assign active = (state_q == StActive);

   always_comb begin
      state_d   = state_q;
      mask_d    = mask_q;
      addr_d    = addr_q;
      wb_addr_d = wb_addr_q;
      done_d    = 1'b0;
      if (start_i) begin
         mask_d    = reglist_i;
         addr_d    = start_addr;
         wb_addr_d = increment_i ? (base_i + cnt_ext) : (base_i - cnt_ext);
         if (cnt != '0) begin
            state_d = StActive;
         end else begin
            // Empty list completes immediately.
            state_d = StIdle;
            done_d  = 1'b1;
         end
      end else if (flush_i) begin
         state_d = StIdle;
         mask_d  = '0;
      end else if (active && advance_i) begin
         mask_d = mask_q & ~low_clr;
         addr_d = addr_q + AddrOne;
         if (mask_single) begin
            state_d = StIdle;
            done_d  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         mask_q    <= '0;
         addr_q    <= '0;
         wb_addr_q <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         mask_q    <= mask_d;
         addr_q    <= addr_d;
         wb_addr_q <= wb_addr_d;
         done_q    <= done_d;
      end
   end

   assign pop_valid_o = active && mask_nonzero;
   assign popped_o    = low_idx;
   assign addr_o      = addr_q;
   assign last_o      = active && mask_single;
   assign busy_o      = active;
   assign done_o      = done_q;
   assign wb_addr_o   = wb_addr_q;

endmodule

// File: tb/tb_core_control_ldst_reglist.sv
module tb_core_control_ldst_reglist;

   localparam int unsigned AW = 30;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          start = 1'b0;
   logic [15:0]   rl = '0;
   logic [AW-1:0] base = '0;
   logic          inc = 1'b0;
   logic          pre = 1'b0;
   logic          adv = 1'b0;
   logic          flush = 1'b0;

   logic          pop_valid;
   logic [3:0]    popped;
   logic [AW-1:0] addr;
   logic          last;
   logic          busy;
   logic          done;
   logic [AW-1:0] wb_addr;

   core_control_ldst_reglist dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_i     (start),
      .reglist_i   (rl),
      .base_i      (base),
      .increment_i (inc),
      .pre_index_i (pre),
      .advance_i   (adv),
      .flush_i     (flush),
      .pop_valid_o (pop_valid),
      .popped_o    (popped),
      .addr_o      (addr),
      .last_o      (last),
      .busy_o      (busy),
      .done_o      (done),
      .wb_addr_o   (wb_addr)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en = 1'b0;

   // Model: the outstanding beats as a queue of (register, address).
   typedef struct packed {
      logic [3:0]    r;
      logic [AW-1:0] a;
   } beat_t;

   beat_t         mq[$];
   logic [AW-1:0] m_wb = '0;
   logic          m_done = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_wb   = '0;
      m_done = 1'b0;
   endtask

   // Applies the inputs that were present at the clock edge just taken.
   task automatic model_step();
      int n;
      logic [AW-1:0] a;
      if (!rst_n) begin
         model_reset();
         return;
      end
      m_done = 1'b0;
      if (start) begin
         n = $countones(rl);
         if (inc) a = pre ? base + AW'(1) : base;
         else     a = pre ? base - AW'(n) : base - AW'(n) + AW'(1);
         mq.delete();
         for (int r = 0; r < 16; r++) begin
            if (rl[r]) begin
               mq.push_back('{r: 4'(r), a: a});
               a = a + AW'(1);
            end
         end
         m_wb = inc ? base + AW'(n) : base - AW'(n);
         if (n == 0) m_done = 1'b1;
      end else if (flush) begin
         mq.delete();
      end else if (adv && mq.size() > 0) begin
         void'(mq.pop_front());
         if (mq.size() == 0) m_done = 1'b1;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic issue(input logic [15:0] l, input logic [AW-1:0] b, input logic i,
                        input logic p);
      rl    = l;
      base  = b;
      inc   = i;
      pre   = p;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic run_until_done(input int bound, input string name);
      bit seen = 1'b0;
      for (int k = 0; k < bound; k++) begin
         tick();
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      chk({name, " done seen"}, 32'(seen), 32'd1);
   endtask

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("pop_valid", 32'(pop_valid), 32'(mq.size() > 0));
         chk("busy", 32'(busy), 32'(mq.size() > 0));
         chk("last", 32'(last), 32'(mq.size() == 1));
         chk("done", 32'(done), 32'(m_done));
         chk("wb_addr", 32'(wb_addr), 32'(m_wb));
         if (mq.size() > 0) begin
            chk("popped", 32'(popped), 32'(mq[0].r));
            chk("addr", 32'(addr), 32'(mq[0].a));
         end
      end
   end

   initial begin
      #200000;
      n_errors++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #1 rst_n = 1'b0;
      #2;
      chk("rst pop_valid", 32'(pop_valid), 32'd0);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst done", 32'(done), 32'd0);
      chk("rst addr", 32'(addr), 32'd0);
      chk("rst wb_addr", 32'(wb_addr), 32'd0);
      tick();
      tick();
      rst_n  = 1'b1;
      chk_en = 1'b1;

      // 1: IA, three registers, advance held.
      adv = 1'b1;
      issue(16'h8006, 30'h100, 1'b1, 1'b0);
      chk("t1 b1 reg", 32'(popped), 32'd1);
      chk("t1 b1 addr", 32'(addr), 32'h100);
      chk("t1 wb", 32'(wb_addr), 32'h103);
      tick();
      chk("t1 b2 reg", 32'(popped), 32'd2);
      chk("t1 b2 addr", 32'(addr), 32'h101);
      tick();
      chk("t1 b3 reg", 32'(popped), 32'd15);
      chk("t1 b3 addr", 32'(addr), 32'h102);
      chk("t1 b3 last", 32'(last), 32'd1);
      tick();
      chk("t1 done", 32'(done), 32'd1);
      tick();
      chk("t1 done clr", 32'(done), 32'd0);

      // 2: DB then IB on the same list.
      issue(16'h00F0, 30'h200, 1'b0, 1'b1);
      chk("t2 db reg", 32'(popped), 32'd4);
      chk("t2 db addr", 32'(addr), 32'h1FC);
      chk("t2 db wb", 32'(wb_addr), 32'h1FC);
      tick();
      tick();
      tick();
      chk("t2 db last reg", 32'(popped), 32'd7);
      chk("t2 db last addr", 32'(addr), 32'h1FF);
      tick();
      chk("t2 db done", 32'(done), 32'd1);
      issue(16'h00F0, 30'h200, 1'b1, 1'b1);
      chk("t2 ib addr", 32'(addr), 32'h201);
      chk("t2 ib wb", 32'(wb_addr), 32'h204);
      run_until_done(8, "t2 ib");

      // DA: bottom of block is base-N+1.
      issue(16'h0005, 30'h300, 1'b0, 1'b0);
      chk("da addr", 32'(addr), 32'h2FF);
      chk("da wb", 32'(wb_addr), 32'h2FE);
      run_until_done(8, "da");

      // 3: stall for three cycles.
      adv = 1'b0;
      issue(16'h0003, 30'h300, 1'b1, 1'b0);
      for (int k = 0; k < 3; k++) begin
         chk("t3 stall reg", 32'(popped), 32'd0);
         chk("t3 stall addr", 32'(addr), 32'h300);
         tick();
      end
      adv = 1'b1;
      tick();
      chk("t3 b2 reg", 32'(popped), 32'd1);
      chk("t3 b2 addr", 32'(addr), 32'h301);
      tick();
      chk("t3 done", 32'(done), 32'd1);
      tick();
      chk("t3 done once", 32'(done), 32'd0);

      // 4: empty list.
      adv = 1'b0;
      issue(16'h0000, 30'h55, 1'b1, 1'b0);
      chk("t4 pop_valid", 32'(pop_valid), 32'd0);
      chk("t4 done", 32'(done), 32'd1);
      chk("t4 wb", 32'(wb_addr), 32'h55);
      tick();
      chk("t4 done once", 32'(done), 32'd0);

      // 5a: flush after the first beat.
      adv = 1'b1;
      issue(16'h0F00, 30'h10, 1'b1, 1'b0);
      tick();
      adv   = 1'b0;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("t5 flush busy", 32'(busy), 32'd0);
      chk("t5 flush done", 32'(done), 32'd0);
      chk("t5 flush wb", 32'(wb_addr), 32'h14);
      tick();
      chk("t5 flush no done", 32'(done), 32'd0);

      // 5b: asynchronous reset mid-sequence.
      issue(16'h00FF, 30'h40, 1'b1, 1'b0);
      tick();
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      chk("t5 rst pop_valid", 32'(pop_valid), 32'd0);
      chk("t5 rst popped", 32'(popped), 32'd0);
      chk("t5 rst addr", 32'(addr), 32'd0);
      chk("t5 rst last", 32'(last), 32'd0);
      chk("t5 rst busy", 32'(busy), 32'd0);
      chk("t5 rst wb", 32'(wb_addr), 32'd0);
      tick();
      rst_n = 1'b1;

      // 5c: address wrap.
      adv = 1'b1;
      issue(16'h0003, 30'h3FFFFFFF, 1'b1, 1'b0);
      chk("t5 wrap a0", 32'(addr), 32'h3FFFFFFF);
      chk("t5 wrap wb", 32'(wb_addr), 32'h1);
      tick();
      chk("t5 wrap a1", 32'(addr), 32'h0);
      chk("t5 wrap r1", 32'(popped), 32'd1);
      tick();

      // 6: start on the final advance of the previous list.
      issue(16'h0003, 30'h500, 1'b1, 1'b0);
      tick();
      issue(16'h0030, 30'h600, 1'b1, 1'b0);
      chk("t6 reg", 32'(popped), 32'd4);
      chk("t6 addr", 32'(addr), 32'h600);
      chk("t6 no done", 32'(done), 32'd0);
      tick();
      chk("t6 b2 reg", 32'(popped), 32'd5);
      chk("t6 b2 done", 32'(done), 32'd0);
      tick();
      chk("t6 done", 32'(done), 32'd1);
      adv = 1'b0;
      tick();
      tick();

      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/core_control_ldst_reglist.md
Name: core_control_ldst_reglist

Overview:
Register-list sequencer for LDM/STM block transfers in the control unit. It sits directly upstream of the register-select stage.
- On issue it latches the 16-bit register list and base word address.
- Each cycle it presents the next register to transfer (lowest-numbered first) via pop_valid/popped, together with its word address.
- It advances when the memory stage accepts a beat, and reports completion and the writeback base value.

Parameters:
ADDR_W, 30, word-address width (byte address bits [31:2]).
NREGS, 16, architectural register-list width; popped width is $clog2(NREGS).

Ports:
clk  in  1  core clock.
rst_n  in  1  asynchronous active-low reset.
start  in  1  latch new transfer (issue cycle of LDM/STM).
reglist  in  NREGS  register list from decode.
base  in  ADDR_W  base register value (word address).
increment  in  1  1 = IA/IB, 0 = DA/DB.
pre_index  in  1  1 = IB/DB (address adjusted before first beat).
advance  in  1  memory accepted current beat (mem_ready in TRANSFER).
flush  in  1  abort, for example on data abort or pipeline flush.
pop_valid  out  1  popped/addr are valid.
popped  out  4  register number for current beat (reg_num).
addr  out  ADDR_W  word address of current beat.
last  out  1  current beat is the final one.
busy  out  1  sequence in progress.
done  out  1  one-cycle pulse after final beat accepted.
wb_addr  out  ADDR_W  base writeback value, valid from the cycle after start until the next start.

Behaviour:
- Reset (rst_n low, asynchronous) forces the following outputs to 0:
  - state = IDLE, mask, addr, wb_addr, done, busy, pop_valid.
- Two states, IDLE and ACTIVE. done is a separate registered pulse.
- start (any state) latches the transfer; start takes priority over advance and flush in the same cycle.
  - mask <= reglist.
  - N = popcount(reglist), 5 bits, range 0..16.
  - Start address:
    - IA: base
    - IB: base+1
    - DA: base-N+1
    - DB: base-N
  - Arithmetic is modulo 2^ADDR_W and wraps silently.
  - wb_addr <= base+N if increment, else base-N.
  - Next state is ACTIVE if N>0, else IDLE with done pulsed next cycle (empty list: no beats, wb_addr = base).
- ACTIVE outputs:
  - pop_valid = 1.
  - popped = index of lowest set bit of mask.
  - last = (mask has exactly one bit set).
  - busy = 1.
- ACTIVE with advance:
  - Clear the lowest set bit of mask and set addr <= addr+1. Addresses always ascend; the lowest register is at the lowest address.
  - If last, the next state is IDLE and done = 1 in the following cycle only.
- ACTIVE without advance: hold all state. popped and addr stay stable while stalled.
- flush without start: state to IDLE, mask cleared, no done pulse, wb_addr retained.
- advance in IDLE is ignored.
- popped/last are combinational from mask; addr is registered. Zero added latency: the first beat is valid the cycle after start.
- A start on the same cycle as the final advance starts the new list. done is suppressed.

Decomposition:
- reg_num, ptr and the ldst addressing-mode encodings (IA/IB/DA/DB) belong in the shared core/uarch.sv package.
- One sub-module: core_control_ldst_reglist_prio. It is a combinational priority encoder taking the NREGS mask and returning the lowest-set index, a one-hot clear mask, a single-bit flag and a nonzero flag. The popcount lives in the top.

Test Plan:
1. IA, reglist=16'h8006, base=0x100, advance held 1:
   - beats (r1,0x100), (r2,0x101), (r15,0x102); last on 3rd beat.
   - done pulses next cycle; wb_addr=0x103.
2. DB, reglist=16'h00F0, base=0x200:
   - beats r4..r7 at 0x1FC..0x1FF; wb_addr=0x1FC.
   - IB on the same list: 0x201..0x204, wb=0x204.
3. IA, reglist=16'h0003, advance low for 3 cycles then high:
   - popped=r0, addr stable during the stall; then r1.
   - Exactly 2 beats, one done pulse.
4. reglist=0 with start:
   - pop_valid never asserts; done pulses once next cycle; wb_addr=base.
5. Boundaries:
   - flush after 1st beat of a 4-register list: busy=0 next cycle, no done.
   - rst_n asserted mid-sequence: all outputs 0 immediately.
   - IA, base=0x3FFFFFFF, 2 regs: addresses 0x3FFFFFFF then 0x0.
6. start coincident with final advance of a previous list:
   - The new list's first beat is presented the next cycle, with no done pulse.
